rv32_id_top: RTL

Decode stage of the RV32I 5-stage pipeline, directly downstream of the fetch stage. Consumes pc/iw from fetch, reads the external register file, and forwards operands from EX/MEM/WB. Resolves jumps and branches and detects load-use hazards and ECALL/EBREAK halt, feeding redirect, stall and halt back to fetch. Registers the decoded bundle for EX.

---
 rtl/rv32_pkg.sv | 22 ++
 rtl/rv32_imm_gen.sv | 17 +
 rtl/rv32_id_top.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I opcode, branch funct3 and bubble constants for the decode stage
package rv32_pkg;
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_OPIMM  = 7'b0010011,
    OP_OP     = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_e;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [31:0] NOP_IW = 32'h00000013;
endpackage

// File: rtl/rv32_imm_gen.sv
// rv32_imm_gen: sign-extended immediate selected by the opcode's format
//   iw  : instruction word
//   imm : I/S/B/U/J immediate, 0 for formats without one
module rv32_imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] iw,
  output logic [31:0] imm
);
  logic [6:0] opc;
  assign opc = iw[6:0];
  assign imm = (opc == OP_JALR || opc == OP_LOAD || opc == OP_OPIMM || opc == OP_SYSTEM) ? {{20{iw[31]}}, iw[31:20]} :
               opc == OP_STORE ? {{20{iw[31]}}, iw[31:25], iw[11:7]} :
               opc == OP_BRANCH ? {{19{iw[31]}}, iw[31], iw[7], iw[30:25], iw[11:8], 1'b0} :
               (opc == OP_LUI || opc == OP_AUIPC) ? {iw[31:12], 12'b0} :
               opc == OP_JAL ? {{11{iw[31]}}, iw[31], iw[19:12], iw[20], iw[30:21], 1'b0} : 32'b0;
endmodule

// File: rtl/rv32_id_top.sv
// rv32_id_top: RV32I decode stage with forwarding, branch resolution, load-use stall and halt
//   pc_in/iw_in            : fetch inputs
//   rs*_reg_out/rs*_data_in: external regfile read ports
//   ex/mem/wb_fwd_*        : forwarding sources, EX highest priority
//   jump_*_out, halt_flag, lw_stall_* : feedback to fetch
//   pc_out..illegal_out    : registered bundle for EX
module rv32_id_top
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  output logic [4:0]  rs1_reg_out,
  output logic [4:0]  rs2_reg_out,
  input  logic [31:0] rs1_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic        ex_fwd_en,
  input  logic [4:0]  ex_fwd_rd,
  input  logic [31:0] ex_fwd_data,
  input  logic        mem_fwd_en,
  input  logic [4:0]  mem_fwd_rd,
  input  logic [31:0] mem_fwd_data,
  input  logic        wb_fwd_en,
  input  logic [4:0]  wb_fwd_rd,
  input  logic [31:0] wb_fwd_data,
  output logic        jump_enable_out,
  output logic [31:0] jump_addr_out,
  output logic        halt_flag,
  output logic        lw_stall_flag,
  output logic [31:0] lw_stall_pc,
  output logic [31:0] lw_stall_iw,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic [31:0] rs1_data_out,
  output logic [31:0] rs2_data_out,
  output logic [31:0] imm_out,
  output logic [4:0]  rd_out,
  output logic        wb_en_out,
  output logic        is_load_out,
  output logic        illegal_out
);
  logic squash, replay_valid;
  logic [31:0] pc, iw, imm, rs1_val, rs2_val;
  logic [6:0] opc;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] f3;
  logic known, uses_rs1, uses_rs2, writes_rd, cand, live, emit, taken;
  assign pc = replay_valid ? lw_stall_pc : pc_in;
  assign iw = replay_valid ? lw_stall_iw : iw_in;
  assign opc = iw[6:0];
  assign f3 = iw[14:12];
  assign rd = iw[11:7];
  assign rs1 = iw[19:15];
  assign rs2 = iw[24:20];
  assign rs1_reg_out = rs1;
  assign rs2_reg_out = rs2;
  rv32_imm_gen u_imm (.iw(iw), .imm(imm));
  assign rs1_val = rs1 == 5'd0 ? 32'b0 :
                   (ex_fwd_en && ex_fwd_rd == rs1) ? ex_fwd_data :
                   (mem_fwd_en && mem_fwd_rd == rs1) ? mem_fwd_data :
                   (wb_fwd_en && wb_fwd_rd == rs1) ? wb_fwd_data : rs1_data_in;
  assign rs2_val = rs2 == 5'd0 ? 32'b0 :
                   (ex_fwd_en && ex_fwd_rd == rs2) ? ex_fwd_data :
                   (mem_fwd_en && mem_fwd_rd == rs2) ? mem_fwd_data :
                   (wb_fwd_en && wb_fwd_rd == rs2) ? wb_fwd_data : rs2_data_in;
  assign known = opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_SYSTEM};
  assign uses_rs1 = opc inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP};
  assign uses_rs2 = opc inside {OP_BRANCH, OP_STORE, OP_OP};
  assign writes_rd = opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM, OP_OP};
  // Stall only matters for an inst that would otherwise be live; the bubble it
  // inserts clears is_load_out, so the replay can never stall again.
  assign cand = !squash && !halt_flag;
  assign lw_stall_flag = cand && is_load_out && rd_out != 5'd0 &&
                         ((uses_rs1 && rs1 == rd_out) || (uses_rs2 && rs2 == rd_out));
  assign live = cand && !lw_stall_flag;
  assign emit = live && known && opc != OP_SYSTEM;
  always_comb
    taken = f3 == F3_BEQ  ? rs1_val == rs2_val :
            f3 == F3_BNE  ? rs1_val != rs2_val :
            f3 == F3_BLT  ? $signed(rs1_val) < $signed(rs2_val) :
            f3 == F3_BGE  ? $signed(rs1_val) >= $signed(rs2_val) :
            f3 == F3_BLTU ? rs1_val < rs2_val :
            f3 == F3_BGEU ? rs1_val >= rs2_val : 1'b0;
  assign jump_enable_out = live && (opc == OP_JAL || opc == OP_JALR || (opc == OP_BRANCH && taken));
  assign jump_addr_out = opc == OP_JALR ? (rs1_val + imm) & ~32'h1 : pc + imm;
  always_ff @(posedge clk)
    if (reset) begin
      squash       <= 1'b0;
      replay_valid <= 1'b0;
      halt_flag    <= 1'b0;
      lw_stall_pc  <= 32'b0;
      lw_stall_iw  <= 32'b0;
      pc_out       <= 32'b0;
      iw_out       <= NOP_IW;
      rs1_data_out <= 32'b0;
      rs2_data_out <= 32'b0;
      imm_out      <= 32'b0;
      rd_out       <= 5'd0;
      wb_en_out    <= 1'b0;
      is_load_out  <= 1'b0;
      illegal_out  <= 1'b0;
    end else begin
      squash       <= jump_enable_out;
      replay_valid <= lw_stall_flag;
      halt_flag    <= halt_flag | (live && opc == OP_SYSTEM);
      if (lw_stall_flag) begin
        lw_stall_pc <= pc;
        lw_stall_iw <= iw;
      end
      pc_out       <= pc;
      iw_out       <= emit ? iw : NOP_IW;
      rs1_data_out <= emit ? rs1_val : 32'b0;
      rs2_data_out <= emit ? rs2_val : 32'b0;
      imm_out      <= emit ? imm : 32'b0;
      rd_out       <= (emit && writes_rd) ? rd : 5'd0;
      wb_en_out    <= emit && writes_rd && rd != 5'd0;
      is_load_out  <= emit && opc == OP_LOAD;
      illegal_out  <= live && !known;
    end
endmodule
